// File: rtl/btu_input_collector.sv
// Collects a stream of input words plus the bit width n into one bundle for the
// bit transpose core, with short-batch (in_last) and back-to-back batch support.
module btu_input_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned MAX_N      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [DATA_WIDTH-1:0]                in_data_i,
  input  logic [4:0]                           in_n_i,
  input  logic                                 in_last_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [5+NUM_WORDS*DATA_WIDTH-1:0]    out_bundle_o,
  output logic [5:0]                           word_cnt_o,
  output logic                                 err_n_o
);

  localparam int unsigned IdxW    = $clog2(NUM_WORDS);
  localparam logic [5:0]  LastIdx = 6'(NUM_WORDS - 1);
  localparam logic [4:0]  MaxN    = 5'(MAX_N);

  typedef enum logic {StFill, StFull} state_e;

  state_e                               state_q, state_d;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [4:0]                           n_q, n_d;
  logic [5:0]                           cnt_q, cnt_d;
  logic                                 err_q, err_d;

  logic       accept;
  logic       batch_done;
  logic       n_illegal;
  logic [5:0] wr_idx;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // A word accepted while FULL can only happen during the output handshake,
  // so it always starts the next batch at index 0.
  assign accept     = in_valid_i & in_ready_o;
  assign wr_idx     = (state_q == StFull) ? 6'd0 : cnt_q;
  assign batch_done = accept & (in_last_i | (wr_idx == LastIdx));
  assign n_illegal  = (in_n_i == 5'd0) || (in_n_i > MaxN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (batch_done) state_d = StFull;
      StFull: if (out_ready_i) state_d = batch_done ? StFull : StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    unique case (state_q)
      StFill: ;
      StFull: begin
        in_ready_o  = out_ready_i;
        out_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_d = data_q;
    n_d    = n_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if ((state_q == StFull) && out_ready_i) cnt_d = 6'd0;
    if (accept) begin
      if (wr_idx == 6'd0) begin
        data_d = '0;
        n_d    = n_illegal ? MaxN : in_n_i;
        err_d  = n_illegal;
      end
      data_d[wr_idx[IdxW-1:0]] = in_data_i;
      cnt_d = wr_idx + 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign out_bundle_o = {n_q, data_q};
  assign word_cnt_o   = cnt_q;
  assign err_n_o      = err_q;

endmodule
